// File: rtl/uart_defs_pkg.sv
// Shared definitions for the output-port UART transmitter.
// Holds the one-hot TX FSM state encodings and the default bit period
// for a 100 MHz system clock driving a 115200 baud line.
package uart_defs;

  localparam logic [3:0] IDLE  = 4'b0001;
  localparam logic [3:0] START = 4'b0010;
  localparam logic [3:0] DATA  = 4'b0100;
  localparam logic [3:0] STOP  = 4'b1000;

  // 100_000_000 / 115_200 rounded to the nearest cycle.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/out_port_uart_tx_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO.
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   push, din      write request and data (ignored while full)
//   pop            read request (ignored while empty)
//   dout           head entry, valid whenever empty is low
//   count          occupancy 0..FIFO_DEPTH
//   full, empty    occupancy flags, derived from count
module byte_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Full/empty come from the pre-edge count, so a push while full is
  // dropped even when a pop happens on the same edge.
  assign full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // Storage is not reset; reset only discards it through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: captures bytes written to a processor output port and
// sends them as 8N1 UART frames.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   port_data       byte presented by the processor
//   port_strobe_n   active-low write strobe, one cycle per write
//   tx              serial output, idle high
//   busy            frame in progress or bytes still queued
//   fifo_count      queued bytes, 0..FIFO_DEPTH
//   overflow        sticky flag: a byte arrived while the queue was full
module out_port_uart_tx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        port_data,
  input  logic              port_strobe_n,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          strobe_prev;
  logic          armed;
  logic          write_det;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          bit_end;

  // armed stays low until the strobe has been seen high once after reset,
  // so a strobe held low through reset release is not taken as a write.
  assign write_det = armed & strobe_prev & ~port_strobe_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_prev <= 1'b1;
      armed       <= 1'b0;
    end else begin
      strobe_prev <= port_strobe_n;
      if (port_strobe_n) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (write_det & fifo_full) overflow <= 1'b1;
  end

  assign pop = (state == IDLE) & ~fifo_empty;

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (write_det),
    .pop  (pop),
    .din  (port_data),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            tx        <= 1'b0;
            baud_cnt  <= '0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Next bit is taken from the pre-shift register.
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else baud_cnt <= baud_cnt + 1'b1;
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_uart_tx.sv
module tb_out_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    port_data;
  logic          port_strobe_n;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int peak   = 0;

  always #5 clk = ~clk;

  out_port_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_data    (port_data),
    .port_strobe_n(port_strobe_n),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  // Reference model: a byte queue plus a frame timer. A frame is
  // 10*CPB cycles of {stop, data LSB-first, start}; the next byte can
  // start only on the cycle after the timer expires.
  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'h00;
  int         m_rem = 0;
  bit         m_ovf = 0;
  bit         m_prev = 1;
  bit         m_arm = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_rem  = 0;
      m_ovf  = 0;
      m_prev = 1;
      m_arm  = 0;
    end else begin
      int  cnt;
      bit  wr;
      cnt = mq.size();
      wr  = m_arm && m_prev && !port_strobe_n;
      if (m_rem == 0 && cnt > 0) begin
        m_cur = mq.pop_front();
        m_rem = 10 * CPB;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
      if (wr) begin
        if (cnt < DEPTH) mq.push_back(port_data);
        else m_ovf = 1;
      end
      m_prev = port_strobe_n;
      if (port_strobe_n) m_arm = 1;
    end
  end

  function automatic logic m_tx();
    logic [9:0] fr;
    int k;
    if (m_rem == 0) return 1'b1;
    fr = {1'b1, m_cur, 1'b0};
    k  = (10 * CPB - m_rem) / CPB;
    return fr[k];
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    port_strobe_n = 1'b0;
    port_data     = d;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    port_strobe_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    port_strobe_n = 1'b1;
    port_data = 8'h00;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    fork
      forever begin
        @(negedge clk);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (mon_en)
          chk("cycle{tx,busy,cnt,ovf}", 32'({tx, busy, fifo_count, overflow}),
              32'({m_tx(), (m_rem != 0 || mq.size() != 0), (AW+1)'(mq.size()), m_ovf}));
      end
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({tx, busy, fifo_count, overflow}), 32'({1'b1, 1'b0, 4'd0, 1'b0}));
    reset = 1'b0;
    mon_en = 1;
    repeat (2) @(posedge clk);

    // Single frames: latency, then mid-bit samples against the table.
    foreach (vecs[i]) begin
      strobe(vecs[i].data, 1);
      @(negedge clk);
      chk("latency_pre_tx", 32'(tx), 32'd1);
      chk("latency_cnt", 32'(fifo_count), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("latency_tx_fall", 32'(tx), 32'd0);
      for (int k = 0; k < 10; k++) begin
        repeat (k == 0 ? 1 : CPB) @(posedge clk);
        @(negedge clk);
        chk($sformatf("frame%0d_bit%0d", i, k), 32'(tx), 32'(vecs[i].frame[k]));
      end
      wait_idle(200);
      chk("single_cnt_end", 32'(fifo_count), 32'd0);
    end

    // Burst of three writes three cycles apart.
    @(posedge clk); #1;
    peak = 0;
    strobe(8'h01, 1);
    @(posedge clk); #1;
    strobe(8'h80, 1);
    @(posedge clk); #1;
    strobe(8'hFF, 1);
    wait_idle(500);
    chk("burst_peak", 32'(peak), 32'd2);
    chk("burst_ovf", 32'(overflow), 32'd0);

    // Long strobe: one write only.
    peak = 0;
    strobe(8'h3C, 5);
    wait_idle(200);
    chk("long_peak", 32'(peak), 32'd1);

    // Pointer wrap: 20 isolated writes.
    for (int i = 0; i < 20; i++) begin
      strobe(8'($urandom), 1);
      wait_idle(200);
    end
    chk("wrap_cnt_end", 32'(fifo_count), 32'd0);

    // Overflow: 10 writes two cycles apart into depth 8.
    for (int i = 0; i < 10; i++) strobe(8'(i), 1);
    chk("ovf_full_cnt", 32'(fifo_count), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    wait_idle(2000);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_cnt_end", 32'(fifo_count), 32'd0);

    // Strobe held low across reset release must not write.
    @(posedge clk); #1;
    reset = 1'b1;
    port_strobe_n = 1'b0;
    port_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    port_strobe_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("low_thru_reset_busy", 32'(busy), 32'd0);
    chk("low_thru_reset_cnt", 32'(fifo_count), 32'd0);
    chk("reset_clears_ovf", 32'(overflow), 32'd0);

    // Reset during DATA bit 3 of 0xA5 (that bit is 0).
    strobe(8'hA5, 1);
    repeat (1 + 4 * CPB + 1) @(posedge clk);
    #1;
    chk("mid_frame_tx_low", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({tx, busy, fifo_count, overflow}), 32'({1'b1, 1'b0, 4'd0, 1'b0}));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("post_reset_idle", 32'({tx, busy}), 32'({1'b1, 1'b0}));

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      strobe(8'($urandom), int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end
    wait_idle(3000);
    chk("random_cnt_end", 32'(fifo_count), 32'(mq.size()));

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
Downstream consumer of one processor output port. It captures each byte the processor writes, signalled by the one-cycle active-low output strobe, into a small FIFO. It then serialises the bytes as 8N1 UART frames on the Basys3 USB-UART TX pin. This decouples instruction-rate OUTPUT bursts from the slow serial line and flags dropped bytes.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
port_data  input  8  processor out_port_N value; stable while its strobe is low.
port_strobe_n  input  1  processor out_strobe[N]; low for exactly 1 cycle per write.
tx  output  1  UART serial out; idle high.
busy  output  1  high while a frame is in progress or the FIFO is non-empty.
fifo_count  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
overflow  output  1  sticky; set when a byte is dropped; cleared only by reset.

Behaviour:
- Reset (async, active-high), applied immediately:
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - FSM=IDLE, rd/wr pointers=0, bit and baud counters=0.
  - strobe history register=1.
- Reset mid-frame aborts the frame and drives tx high at once. FIFO contents are discarded.
- Capture:
  - strobe_prev is a register sampling port_strobe_n each edge.
  - A write is detected at edge n when port_strobe_n=0 and strobe_prev=1.
  - port_data is written at that same edge n.
  - A strobe held low across multiple cycles yields one write.
  - A strobe held low while reset deasserts yields no write until it returns high and falls again.
- FIFO:
  - Synchronous, registered write and read.
  - Full test uses the occupancy before the edge. A write while full is dropped and sets overflow, even if a pop occurs at the same edge.
  - A simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM, one-hot: IDLE=4'b0001, START=4'b0010, DATA=4'b0100, STOP=4'b1000.
  - IDLE: tx=1. If fifo_count != 0, pop the head into shift_reg, set tx<=0, baud_cnt<=0, and go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles. Then tx<=shift_reg[0], bit_cnt<=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, LSB first. At each bit end, shift right. After bit 7 ends, tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - A byte already queued is popped on the first IDLE cycle, so the inter-frame gap is exactly 1 clk.
- Latency: for a write detected at edge n into an empty FIFO, the pop and tx falling occur at edge n+1.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frame period: 10*CLKS_PER_BIT+1 cycles.
- busy = (FSM != IDLE) | (fifo_count != 0), registered-equivalent.
- tx, busy, fifo_count and overflow are driven from registers; there are no combinational paths from inputs.
- baud_cnt width: ceil(log2(CLKS_PER_BIT)); it counts 0..CLKS_PER_BIT-1 with no wrap overrun.

Decomposition:
- Shared package/header (uart_defs):
  - FSM state constants IDLE/START/DATA/STOP (one-hot, 4-bit).
  - Default CLKS_PER_BIT for a 100 MHz clock.
- One natural sub-module: byte_fifo (parameterised FIFO_DEPTH/ADDR_W).
  - Inputs: push, pop, din. Outputs: dout, count, full, empty.
  - Same clock and reset convention.
- The top level holds the strobe edge detector, the overflow flag and the TX FSM.

Test Plan:
- Single byte, CLKS_PER_BIT=4: strobe low 1 cycle with port_data=8'hA5.
  - tx falls at edge n+1; sampled bits (LSB first) are 0,1,0,1,0,0,1,0,1 then stop bit 1.
  - Frame is 40 cycles; busy drops at the edge following STOP end; fifo_count returns to 0.
- Burst: 3 strobes 3 cycles apart with 8'h01, 8'h80, 8'hFF.
  - Three frames in order, separated by exactly 1 idle-high cycle.
  - fifo_count peaks at 2; overflow stays 0.
- Overflow, FIFO_DEPTH=8: 10 strobes 2 cycles apart with values 0..9.
  - The first byte is popped immediately. Bytes 0..8 are transmitted and byte 9 is dropped.
  - overflow=1 and stays 1 after the FIFO drains.
- Long strobe: port_strobe_n held low 5 cycles with port_data=8'h3C.
  - Exactly one frame is sent; fifo_count never exceeds 1.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx goes to 1 asynchronously before the next clk edge; all outputs return to reset values.
  - After release with no strobe, tx stays 1 and busy stays 0.
- Pointer wrap: 20 single writes, each issued after the previous frame finishes.
  - All 20 bytes are received intact and in order; fifo_count is 0 at the end.
